decode_execute_reg: RTL and testbench
=====================================

# decode_execute_reg

Decode-to-execute pipeline register for the five-stage RISC-V core. Captures the decoded instruction and the two source operands read from the 31-entry register file, substitutes write-back data when the same-cycle write targets a source register, detects load-use hazards and inserts a bubble, and honours downstream stall and branch flush. Also counts inserted bubbles for performance debug.

## Interface
- XLEN, 32, datapath width (pc, operands, immediate)
- CTRL_W, 8, width of the opaque execute/memory/write-back control bundle passed through unchanged

- clock  in  1  pipeline clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- id_valid  in  1  decode holds a valid instruction
- id_pc  in  XLEN  instruction address
- id_imm  in  XLEN  decoded immediate
- id_ctrl  in  CTRL_W  control bundle
- id_addr_rs1 / id_addr_rs2 / id_addr_rd  in  5 each  register addresses
- id_use_rs1 / id_use_rs2  in  1 each  instruction actually reads rs1 / rs2
- id_mem_read  in  1  instruction is a load
- id_reg_write  in  1  instruction writes rd
- data_rs1 / data_rs2  in  XLEN each  register-file read data for id_addr_rs1/rs2
- wb_addr_rd  in  5  write-back destination
- wb_data_rd  in  XLEN  write-back data
- wb_write_enable  in  1  write-back is writing this cycle
- ex_stall  in  1  execute cannot accept; hold contents
- flush  in  1  branch/jump redirect; kill decode and this register
- stall_out  out  1  load-use hazard; decode and fetch must hold
- ex_valid  out  1  register holds a valid instruction
- ex_pc, ex_imm, ex_rs1, ex_rs2  out  XLEN each
- ex_ctrl  out  CTRL_W
- ex_addr_rs1, ex_addr_rs2, ex_addr_rd  out  5 each
- ex_mem_read, ex_reg_write  out  1 each
- bubble_count  out  32  number of hazard bubbles inserted since reset

## Operation
- Operand select, per source n in {1,2}: if wb_write_enable and wb_addr_rd != 0 and wb_addr_rd == id_addr_rsn, use wb_data_rd; else if id_addr_rsn == 0, use 0; else data_rsn.
- Hazard (combinational): stall_out = id_valid & ex_valid & ex_mem_read & (ex_addr_rd != 0) & ((id_use_rs1 & id_addr_rs1 == ex_addr_rd) | (id_use_rs2 & id_addr_rs2 == ex_addr_rd)) & !flush.
- Per-edge update, priority order:
  1. flush: ex_valid <= 0, ex_mem_read <= 0, ex_reg_write <= 0; other fields don't-care.
  2. ex_stall: all outputs hold (including ex_valid); bubble_count holds.
  3. stall_out: insert bubble: ex_valid, ex_mem_read, ex_reg_write <= 0; bubble_count += 1.
  4. otherwise load: ex_valid <= id_valid; all fields from id_* and selected operands; ex_mem_read/ex_reg_write gated by id_valid.
- Modes: LOAD (normal), BUBBLE (hazard), HOLD (ex_stall), KILL (flush); evaluated each cycle, no multi-cycle sequence.
- A bubble clears ex_mem_read, so the hazard is at most one cycle per load.
- ex_stall together with a hazard: hold wins, stall_out stays asserted, no count.
- bubble_count wraps modulo 2^32.

## Timing
- Reset (asynchronous, on reset_n low): every output register 0 (ex_valid, fields, bubble_count); stall_out therefore 0.
- Latency: one cycle from id_* to ex_*.
- stall_out is a same-cycle function of registered EX state and current id_* inputs; no registered delay.
- Reset deasserted mid-stream: first edge after release performs a normal load.
- Write-back bypass uses the wb_* values present in the cycle of capture; a write to x0 is never bypassed.

## Test plan
- Reset: hold reset_n low, drive id_valid=1 -> all ex_* = 0, stall_out = 0, bubble_count = 0; release -> next edge loads id_pc=0x100.
- Bypass: id_addr_rs1=5, data_rs1=0x11, wb_write_enable=1, wb_addr_rd=5, wb_data_rd=0xAB -> ex_rs1 = 0xAB; repeat with wb_addr_rd=0 and id_addr_rs1=0 -> ex_rs1 = 0.
- Load-use: EX holds load x7 (ex_mem_read=1), decode add x8,x7,x1 -> stall_out = 1 one cycle, ex_valid = 0 next edge, bubble_count = 1; following edge loads the add with stall_out = 0.
- No false hazard: same as above with id_use_rs1=0 (e.g. lui) or ex_addr_rd=0 -> stall_out = 0, no bubble.
- Flush vs stall: flush=1 with ex_stall=1 and hazard present -> ex_valid = 0, stall_out = 0, bubble_count unchanged.
- Hold: ex_stall=1 for 3 cycles with changing id_* -> ex_* unchanged throughout, then loads the current id_* on release.

Source files
------------

// File: rtl/decode_execute_reg.sv
// Decode-to-execute pipeline register with write-back bypass, load-use bubble
// insertion, execute stall hold, branch flush and a hazard bubble counter.
module decode_execute_reg #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [4:0]        id_addr_rs1,
  input  logic [4:0]        id_addr_rs2,
  input  logic [4:0]        id_addr_rd,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_mem_read,
  input  logic              id_reg_write,
  input  logic [XLEN-1:0]   data_rs1,
  input  logic [XLEN-1:0]   data_rs2,
  input  logic [4:0]        wb_addr_rd,
  input  logic [XLEN-1:0]   wb_data_rd,
  input  logic              wb_write_enable,
  input  logic              ex_stall,
  input  logic              flush,
  output logic              stall_out,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_imm,
  output logic [XLEN-1:0]   ex_rs1,
  output logic [XLEN-1:0]   ex_rs2,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [4:0]        ex_addr_rs1,
  output logic [4:0]        ex_addr_rs2,
  output logic [4:0]        ex_addr_rd,
  output logic              ex_mem_read,
  output logic              ex_reg_write,
  output logic [31:0]       bubble_count
);

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_q, pc_d, imm_q, imm_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [4:0]        addr_rs1_q, addr_rs1_d, addr_rs2_q, addr_rs2_d, addr_rd_q, addr_rd_d;
  logic              mem_read_q, mem_read_d, reg_write_q, reg_write_d;
  logic [31:0]       bubble_count_q, bubble_count_d;
  logic              hazard;

  // A same-cycle write-back wins over the register file; x0 always reads zero.
  function automatic logic [XLEN-1:0] sel_operand(
    input logic [4:0]      addr,
    input logic [XLEN-1:0] rf_data,
    input logic            wb_en,
    input logic [4:0]      wb_addr,
    input logic [XLEN-1:0] wb_data
  );
    if (wb_en && (wb_addr != 5'd0) && (wb_addr == addr)) return wb_data;
    else if (addr == 5'd0)                               return '0;
    else                                                 return rf_data;
  endfunction

  always_comb begin
    hazard = id_valid && valid_q && mem_read_q && (addr_rd_q != 5'd0) &&
             ((id_use_rs1 && (id_addr_rs1 == addr_rd_q)) ||
              (id_use_rs2 && (id_addr_rs2 == addr_rd_q))) && !flush;
  end

  assign stall_out = hazard;

  always_comb begin
    valid_d        = valid_q;
    pc_d           = pc_q;
    imm_d          = imm_q;
    rs1_d          = rs1_q;
    rs2_d          = rs2_q;
    ctrl_d         = ctrl_q;
    addr_rs1_d     = addr_rs1_q;
    addr_rs2_d     = addr_rs2_q;
    addr_rd_d      = addr_rd_q;
    mem_read_d     = mem_read_q;
    reg_write_d    = reg_write_q;
    bubble_count_d = bubble_count_q;
    if (flush) begin
      valid_d     = 1'b0;
      mem_read_d  = 1'b0;
      reg_write_d = 1'b0;
    end else if (ex_stall) begin
      // hold everything, including a pending hazard's count
    end else if (hazard) begin
      valid_d        = 1'b0;
      mem_read_d     = 1'b0;
      reg_write_d    = 1'b0;
      bubble_count_d = bubble_count_q + 32'd1;
    end else begin
      valid_d     = id_valid;
      pc_d        = id_pc;
      imm_d       = id_imm;
      rs1_d       = sel_operand(id_addr_rs1, data_rs1, wb_write_enable, wb_addr_rd, wb_data_rd);
      rs2_d       = sel_operand(id_addr_rs2, data_rs2, wb_write_enable, wb_addr_rd, wb_data_rd);
      ctrl_d      = id_ctrl;
      addr_rs1_d  = id_addr_rs1;
      addr_rs2_d  = id_addr_rs2;
      addr_rd_d   = id_addr_rd;
      mem_read_d  = id_mem_read && id_valid;
      reg_write_d = id_reg_write && id_valid;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q        <= 1'b0;
      pc_q           <= '0;
      imm_q          <= '0;
      rs1_q          <= '0;
      rs2_q          <= '0;
      ctrl_q         <= '0;
      addr_rs1_q     <= 5'd0;
      addr_rs2_q     <= 5'd0;
      addr_rd_q      <= 5'd0;
      mem_read_q     <= 1'b0;
      reg_write_q    <= 1'b0;
      bubble_count_q <= 32'd0;
    end else begin
      valid_q        <= valid_d;
      pc_q           <= pc_d;
      imm_q          <= imm_d;
      rs1_q          <= rs1_d;
      rs2_q          <= rs2_d;
      ctrl_q         <= ctrl_d;
      addr_rs1_q     <= addr_rs1_d;
      addr_rs2_q     <= addr_rs2_d;
      addr_rd_q      <= addr_rd_d;
      mem_read_q     <= mem_read_d;
      reg_write_q    <= reg_write_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_pc        = pc_q;
  assign ex_imm       = imm_q;
  assign ex_rs1       = rs1_q;
  assign ex_rs2       = rs2_q;
  assign ex_ctrl      = ctrl_q;
  assign ex_addr_rs1  = addr_rs1_q;
  assign ex_addr_rs2  = addr_rs2_q;
  assign ex_addr_rd   = addr_rd_q;
  assign ex_mem_read  = mem_read_q;
  assign ex_reg_write = reg_write_q;
  assign bubble_count = bubble_count_q;

endmodule

// File: tb/tb_decode_execute_reg.sv
// Bench for decode_execute_reg: directed vector table, randomized traffic
// against a cycle-level reference model, and asynchronous reset checks.
module tb_decode_execute_reg;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        id_valid, id_use_rs1, id_use_rs2, id_mem_read, id_reg_write;
  logic [31:0] id_pc, id_imm, data_rs1, data_rs2, wb_data_rd;
  logic [7:0]  id_ctrl;
  logic [4:0]  id_addr_rs1, id_addr_rs2, id_addr_rd, wb_addr_rd;
  logic        wb_write_enable, ex_stall, flush;
  logic        stall_out, ex_valid, ex_mem_read, ex_reg_write;
  logic [31:0] ex_pc, ex_imm, ex_rs1, ex_rs2, bubble_count;
  logic [7:0]  ex_ctrl;
  logic [4:0]  ex_addr_rs1, ex_addr_rs2, ex_addr_rd;

  always #5 clock = ~clock;

  decode_execute_reg #(.XLEN(32), .CTRL_W(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .id_addr_rs1(id_addr_rs1), .id_addr_rs2(id_addr_rs2), .id_addr_rd(id_addr_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_mem_read(id_mem_read), .id_reg_write(id_reg_write),
    .data_rs1(data_rs1), .data_rs2(data_rs2),
    .wb_addr_rd(wb_addr_rd), .wb_data_rd(wb_data_rd), .wb_write_enable(wb_write_enable),
    .ex_stall(ex_stall), .flush(flush), .stall_out(stall_out),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_ctrl(ex_ctrl), .ex_addr_rs1(ex_addr_rs1), .ex_addr_rs2(ex_addr_rs2),
    .ex_addr_rd(ex_addr_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .bubble_count(bubble_count)
  );

  typedef struct packed {
    logic        v;
    logic [31:0] pc, imm;
    logic [7:0]  ctrl;
    logic [4:0]  a1, a2, rd;
    logic        u1, u2, mr, rw;
    logic [31:0] d1, d2;
    logic        wbe;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic        stl, fl;
  } in_t;

  typedef struct packed {
    logic        v, mr, rw;
    logic [31:0] pc, imm, rs1, rs2;
    logic [7:0]  ctrl;
    logic [4:0]  a1, a2, rd;
  } ex_t;

  typedef struct {
    in_t         in;
    logic        e_stall, e_valid;
    logic [31:0] e_pc, e_rs1, e_rs2, e_cnt;
  } vec_t;

  ex_t         m;
  int unsigned mcnt;
  int          ntests = 0;
  int          nfail  = 0;
  vec_t        tab[22];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic in_t mk(input logic v, input logic [31:0] pc, input logic [4:0] a1, a2, rd,
                             input logic u1, u2, mr, rw, input logic [31:0] d1, d2,
                             input logic wbe, input logic [4:0] wba, input logic [31:0] wbd,
                             input logic stl, fl);
    in_t x;
    x.v = v; x.pc = pc; x.imm = pc + 32'd4; x.ctrl = pc[7:0] ^ 8'h5A;
    x.a1 = a1; x.a2 = a2; x.rd = rd; x.u1 = u1; x.u2 = u2; x.mr = mr; x.rw = rw;
    x.d1 = d1; x.d2 = d2; x.wbe = wbe; x.wba = wba; x.wbd = wbd; x.stl = stl; x.fl = fl;
    return x;
  endfunction

  task automatic drive(input in_t x);
    id_valid = x.v; id_pc = x.pc; id_imm = x.imm; id_ctrl = x.ctrl;
    id_addr_rs1 = x.a1; id_addr_rs2 = x.a2; id_addr_rd = x.rd;
    id_use_rs1 = x.u1; id_use_rs2 = x.u2; id_mem_read = x.mr; id_reg_write = x.rw;
    data_rs1 = x.d1; data_rs2 = x.d2;
    wb_write_enable = x.wbe; wb_addr_rd = x.wba; wb_data_rd = x.wbd;
    ex_stall = x.stl; flush = x.fl;
  endtask

  // Reference: the operand an instruction should see given this cycle's write-back.
  function automatic logic [31:0] operand(input in_t x, input logic [4:0] a, input logic [31:0] d);
    if (x.wbe && x.wba != 0 && x.wba == a) return x.wbd;
    if (a == 0) return 32'd0;
    return d;
  endfunction

  function automatic logic model_hazard(input in_t x);
    logic reads_load_dest;
    reads_load_dest = (x.u1 && x.a1 == m.rd) || (x.u2 && x.a2 == m.rd);
    return x.v && m.v && m.mr && m.rd != 0 && reads_load_dest && !x.fl;
  endfunction

  task automatic model_update(input in_t x, input logic hz);
    if (x.fl) begin
      m.v = 0; m.mr = 0; m.rw = 0;
    end else if (x.stl) begin
      m = m;
    end else if (hz) begin
      m.v = 0; m.mr = 0; m.rw = 0;
      mcnt = mcnt + 1;
    end else begin
      m.v = x.v; m.mr = x.mr & x.v; m.rw = x.rw & x.v;
      m.pc = x.pc; m.imm = x.imm; m.ctrl = x.ctrl;
      m.a1 = x.a1; m.a2 = x.a2; m.rd = x.rd;
      m.rs1 = operand(x, x.a1, x.d1);
      m.rs2 = operand(x, x.a2, x.d2);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " ex_valid"}, {31'd0, ex_valid}, {31'd0, m.v});
    chk({tag, " ex_mem_read"}, {31'd0, ex_mem_read}, {31'd0, m.mr});
    chk({tag, " ex_reg_write"}, {31'd0, ex_reg_write}, {31'd0, m.rw});
    chk({tag, " bubble_count"}, bubble_count, mcnt);
    if (m.v) begin
      chk({tag, " ex_pc"}, ex_pc, m.pc);
      chk({tag, " ex_imm"}, ex_imm, m.imm);
      chk({tag, " ex_rs1"}, ex_rs1, m.rs1);
      chk({tag, " ex_rs2"}, ex_rs2, m.rs2);
      chk({tag, " ex_ctrl"}, {24'd0, ex_ctrl}, {24'd0, m.ctrl});
      chk({tag, " ex_addrs"}, {17'd0, ex_addr_rs1, ex_addr_rs2, ex_addr_rd},
          {17'd0, m.a1, m.a2, m.rd});
    end
  endtask

  // One pipeline cycle: check the combinational stall, clock, check registered state.
  task automatic step(input in_t x, input string tag, output logic pre_stall);
    logic hz;
    drive(x);
    #1;
    hz = model_hazard(x);
    pre_stall = stall_out;
    chk({tag, " stall_out"}, {31'd0, stall_out}, {31'd0, hz});
    model_update(x, hz);
    @(posedge clock);
    #1;
    check_model(tag);
  endtask

  initial begin
    logic ps;
    in_t  r;

    tab[0]  = '{mk(1,'h104,5,6,9,1,1,0,1,'h11,'h22,1,5,'hAB,0,0), 0,1,'h104,'hAB,'h22,0};
    tab[1]  = '{mk(1,'h108,0,6,9,1,1,0,1,'h11,'h22,1,0,'hAB,0,0), 0,1,'h108,'h0,'h22,0};
    tab[2]  = '{mk(1,'h10C,3,6,9,1,1,0,1,'h33,'h22,0,6,'hCC,0,0), 0,1,'h10C,'h33,'h22,0};
    tab[3]  = '{mk(1,'h110,2,0,7,1,0,1,1,'h1000,'h0,0,0,'h0,0,0), 0,1,'h110,'h1000,'h0,0};
    tab[4]  = '{mk(1,'h114,7,1,8,1,1,0,1,'h77,'h1,0,0,'h0,0,0), 1,0,'h0,'h0,'h0,1};
    tab[5]  = '{mk(1,'h114,7,1,8,1,1,0,1,'h77,'h1,0,0,'h0,0,0), 0,1,'h114,'h77,'h1,1};
    tab[6]  = '{mk(1,'h118,2,0,7,1,0,1,1,'h2000,'h0,0,0,'h0,0,0), 0,1,'h118,'h2000,'h0,1};
    tab[7]  = '{mk(1,'h11C,7,7,9,0,0,0,1,'h55,'h66,0,0,'h0,0,0), 0,1,'h11C,'h55,'h66,1};
    tab[8]  = '{mk(1,'h120,1,0,0,1,0,1,1,'h3000,'h9,0,0,'h0,0,0), 0,1,'h120,'h3000,'h0,1};
    tab[9]  = '{mk(1,'h124,0,2,8,1,1,0,1,'h99,'h44,0,0,'h0,0,0), 0,1,'h124,'h0,'h44,1};
    tab[10] = '{mk(1,'h128,2,0,7,1,0,1,1,'h10,'h0,0,0,'h0,0,0), 0,1,'h128,'h10,'h0,1};
    tab[11] = '{mk(1,'h12C,7,1,8,1,1,0,1,'h77,'h1,0,0,'h0,1,1), 0,0,'h0,'h0,'h0,1};
    tab[12] = '{mk(1,'h130,4,5,3,1,1,0,1,'hA4,'hA5,0,0,'h0,0,0), 0,1,'h130,'hA4,'hA5,1};
    tab[13] = '{mk(1,'h200,1,2,3,1,1,0,1,'h1,'h2,1,1,'hEE,1,0), 0,1,'h130,'hA4,'hA5,1};
    tab[14] = '{mk(1,'h204,3,4,5,1,1,1,1,'h3,'h4,0,0,'h0,1,0), 0,1,'h130,'hA4,'hA5,1};
    tab[15] = '{mk(0,'h208,6,7,1,1,1,0,0,'h5,'h6,1,6,'hDD,1,0), 0,1,'h130,'hA4,'hA5,1};
    tab[16] = '{mk(1,'h20C,1,2,3,1,1,0,1,'h1,'h2,1,1,'hEE,0,0), 0,1,'h20C,'hEE,'h2,1};
    tab[17] = '{mk(1,'h210,2,0,7,1,0,1,1,'h20,'h0,0,0,'h0,0,0), 0,1,'h210,'h20,'h0,1};
    tab[18] = '{mk(1,'h214,1,7,8,0,1,0,1,'h5,'h6,0,0,'h0,1,0), 1,1,'h210,'h20,'h0,1};
    tab[19] = '{mk(1,'h214,1,7,8,0,1,0,1,'h5,'h6,0,0,'h0,0,0), 1,0,'h0,'h0,'h0,2};
    tab[20] = '{mk(1,'h214,1,7,8,0,1,0,1,'h5,'h6,0,0,'h0,0,0), 0,1,'h214,'h5,'h6,2};
    tab[21] = '{mk(0,'h218,1,2,7,1,1,1,1,'h5,'h6,0,0,'h0,0,0), 0,0,'h0,'h0,'h0,2};

    // Reset held while decode presents a valid instruction.
    reset_n = 1'b0;
    drive(mk(1,'h55,3,4,6,1,1,1,1,'h12,'h34,1,3,'h77,0,0));
    m = '0;
    mcnt = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst stall_out", {31'd0, stall_out}, 32'd0);
    chk("rst bubble_count", bubble_count, 32'd0);
    chk("rst ex_pc", ex_pc, 32'd0);
    chk("rst ex_imm", ex_imm, 32'd0);
    chk("rst ex_rs1", ex_rs1, 32'd0);
    chk("rst ex_rs2", ex_rs2, 32'd0);
    chk("rst ctrl/addrs/flags", {13'd0, ex_ctrl, ex_addr_rs1, ex_addr_rs2, ex_addr_rd,
                                 ex_mem_read, ex_reg_write}, 32'd0);
    reset_n = 1'b1;
    step(mk(1,'h100,1,2,3,1,1,0,1,'h1,'h2,0,0,'h0,0,0), "release", ps);
    chk("release ex_pc", ex_pc, 32'h100);

    for (int i = 0; i < 22; i++) begin
      step(tab[i].in, $sformatf("vec%0d", i), ps);
      chk($sformatf("vec%0d tbl stall", i), {31'd0, ps}, {31'd0, tab[i].e_stall});
      chk($sformatf("vec%0d tbl valid", i), {31'd0, ex_valid}, {31'd0, tab[i].e_valid});
      chk($sformatf("vec%0d tbl count", i), bubble_count, tab[i].e_cnt);
      if (tab[i].e_valid) begin
        chk($sformatf("vec%0d tbl pc", i), ex_pc, tab[i].e_pc);
        chk($sformatf("vec%0d tbl rs1", i), ex_rs1, tab[i].e_rs1);
        chk($sformatf("vec%0d tbl rs2", i), ex_rs2, tab[i].e_rs2);
      end
    end

    // Randomized traffic with a small register window so hazards and bypasses are frequent.
    for (int i = 0; i < 400; i++) begin
      r = mk($urandom_range(0, 7) != 0, $urandom, 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, $urandom, $urandom,
             $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
             $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
      r.imm = $urandom;
      r.ctrl = 8'($urandom);
      step(r, "rand", ps);
    end

    // Asynchronous reset asserted between clock edges.
    reset_n = 1'b0;
    #1;
    chk("async rst ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("async rst bubble_count", bubble_count, 32'd0);
    chk("async rst ex_pc", ex_pc, 32'd0);
    #2;
    reset_n = 1'b1;
    m = '0;
    mcnt = 0;
    step(mk(1,'h300,1,2,3,1,1,0,1,'h1,'h2,0,0,'h0,0,0), "re-release", ps);
    chk("re-release ex_pc", ex_pc, 32'h300);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
